// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: single-line fetch buffer returning 64-bit beats
// one cycle after a hit, refilled from a variable-latency memory port on a miss.
module inst_sram_resp #(
   parameter int LINE_BEATS = 4,
   parameter int ADDR_WD    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inst_sram_en,
   input  logic [ADDR_WD-1:0] inst_sram_addr,
   output logic [63:0]        inst_sram_rdata,
   output logic               stall_req,
   input  logic               inval,
   output logic               mem_req,
   output logic [ADDR_WD-1:0] mem_addr,
   input  logic               mem_ready,
   input  logic               mem_rvalid,
   input  logic [63:0]        mem_rdata,
   input  logic               mem_rlast
);

   localparam int BEAT_W = $clog2(LINE_BEATS);
   localparam int OFF_W  = BEAT_W + 3;
   localparam int TAG_W  = ADDR_WD - OFF_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [63:0]        line_buf_q [LINE_BEATS];
   logic [63:0]        line_buf_d [LINE_BEATS];
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               line_valid_q, line_valid_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic               drop_q, drop_d;
   logic [63:0]        rdata_q, rdata_d;
   logic               mem_req_q, mem_req_d;
   logic [ADDR_WD-1:0] mem_addr_q, mem_addr_d;

   logic [TAG_W-1:0]   addr_tag_s;
   logic [BEAT_W-1:0]  addr_beat_s;
   logic               hit_s;
   logic               stall_s;
   logic               unused_s;

   assign addr_tag_s  = inst_sram_addr[ADDR_WD-1:OFF_W];
   assign addr_beat_s = inst_sram_addr[OFF_W-1:3];
   assign hit_s       = line_valid_q & (addr_tag_s == tag_q) & ~inval;
   // rlast is informational only; the beat counter decides when the line is complete
   assign unused_s    = ^{mem_rlast, inst_sram_addr[2:0]};

   // Next-state, buffer refill and response selection
   always_comb begin
      state_d      = state_q;
      line_buf_d   = line_buf_q;
      tag_d        = tag_q;
      line_valid_d = line_valid_q;
      beat_cnt_d   = beat_cnt_q;
      drop_d       = drop_q;
      rdata_d      = rdata_q;
      mem_addr_d   = mem_addr_q;
      stall_s      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (inval) begin
               line_valid_d = 1'b0;
            end else begin
               line_valid_d = line_valid_q;
            end
            if (inst_sram_en && hit_s) begin
               rdata_d = line_buf_q[addr_beat_s];
            end else if (inst_sram_en) begin
               stall_s      = 1'b1;
               mem_addr_d   = {addr_tag_s, {OFF_W{1'b0}}};
               line_valid_d = 1'b0;
               state_d      = S_REQ;
            end else begin
               rdata_d = rdata_q;
            end
         end
         S_REQ: begin
            stall_s = 1'b1;
            drop_d  = drop_q | inval;
            if (mem_ready) begin
               beat_cnt_d = '0;
               state_d    = S_FILL;
            end else begin
               state_d = S_REQ;
            end
         end
         S_FILL: begin
            stall_s = 1'b1;
            drop_d  = drop_q | inval;
            if (mem_rvalid) begin
               line_buf_d[beat_cnt_q] = mem_rdata;
               if (beat_cnt_q == LAST_BEAT) begin
                  // An inval landing on the final beat must also suppress the line
                  tag_d        = mem_addr_q[ADDR_WD-1:OFF_W];
                  line_valid_d = ~(drop_q | inval);
                  drop_d       = 1'b0;
                  beat_cnt_d   = '0;
                  state_d      = S_IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      mem_req_d = (state_d == S_REQ);
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         line_valid_q <= 1'b0;
         beat_cnt_q   <= '0;
         drop_q       <= 1'b0;
         rdata_q      <= 64'd0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         line_valid_q <= line_valid_d;
         beat_cnt_q   <= beat_cnt_d;
         drop_q       <= drop_d;
         rdata_q      <= rdata_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   // Line data storage; contents are meaningless while line_valid is low
   always_ff @(posedge clk) begin
      line_buf_q <= line_buf_d;
   end

   assign inst_sram_rdata = rdata_q;
   assign stall_req       = stall_s;
   assign mem_req         = mem_req_q;
   assign mem_addr        = mem_addr_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp: the driver queues expected beats per request,
// a negedge monitor pops them when the DUT returns data a cycle after acceptance.
module tb_inst_sram_resp;

   localparam int LB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] addr;
   logic [63:0] rdata;
   logic        stall_req;
   logic        inval;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        mem_rlast;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q [$];
   logic        mon_on = 1'b0;
   logic        acc_prev = 1'b0;
   logic        rst_prev = 1'b0;
   logic        stall_prev = 1'b0;
   logic        en_prev = 1'b0;
   logic [31:0] addr_prev = 32'd0;
   logic [63:0] hold = 64'd0;

   inst_sram_resp #(.LINE_BEATS(LB), .ADDR_WD(32)) dut (
      .clk(clk), .rst(rst), .inst_sram_en(en), .inst_sram_addr(addr),
      .inst_sram_rdata(rdata), .stall_req(stall_req), .inval(inval),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
   );

   always #5 clk = ~clk;

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Scoreboard monitor: response check, hold check and requester protocol check
   always @(negedge clk) begin
      if (mon_on) begin
         if (rst_prev) begin
            hold = 64'd0;
            chk64("rdata_after_rst", rdata, 64'd0);
         end else if (acc_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty: response with no expected entry, got 0x%h", rdata);
            end else begin
               hold = exp_q.pop_front();
               chk64("rdata", rdata, hold);
            end
         end else begin
            chk64("rdata_hold", rdata, hold);
         end
         if (stall_prev && en_prev && en) begin
            chk64("proto_addr_stable", {32'd0, addr}, {32'd0, addr_prev});
         end
         acc_prev   = en & ~stall_req & ~rst;
         rst_prev   = rst;
         stall_prev = stall_req;
         en_prev    = en;
         addr_prev  = addr;
      end
   end

   // Miss service: wait_n extra REQ cycles, then LB back-to-back beats
   task automatic do_fill(input logic [31:0] exp_addr, input logic [63:0] base,
                          input int wait_n, input int inval_beat);
      for (int w = 0; w <= wait_n; w++) begin
         go();
         inval     = 1'b0;
         mem_ready = (w == wait_n);
         smp();
         chk1("req_mem_req", mem_req, 1'b1);
         chk64("req_mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr});
         chk1("req_stall", stall_req, 1'b1);
      end
      go();
      mem_ready = 1'b0;
      for (int i = 0; i < LB; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 64'(i);
         mem_rlast  = (i == LB - 1);
         inval      = (i == inval_beat);
         smp();
         chk1("fill_stall", stall_req, 1'b1);
         chk1("fill_mem_req", mem_req, 1'b0);
         go();
      end
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      inval      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; addr = 32'd0; inval = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_rlast = 1'b0;
      repeat (2) go();
      rst = 1'b0;
      smp();
      chk1("rst_stall", stall_req, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk64("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      chk64("rst_rdata", rdata, 64'd0);
      mon_on = 1'b1;

      // Cold miss, mem_ready on the third REQ cycle
      go();
      en = 1'b1; addr = 32'h0000_1004;
      exp_q.push_back(64'h1111_0000_0000_0000);
      smp();
      chk1("miss_stall", stall_req, 1'b1);
      chk1("miss_mem_req", mem_req, 1'b0);
      do_fill(32'h0000_1000, 64'h1111_0000_0000_0000, 2, -1);
      smp();
      chk1("cold_hit_stall", stall_req, 1'b0);

      // Back-to-back hits over the whole line
      for (int k = 0; k < LB; k++) begin
         go();
         addr = 32'h0000_1000 + 32'(k * 8);
         exp_q.push_back(64'h1111_0000_0000_0000 + 64'(k));
         smp();
         chk1("b2b_stall", stall_req, 1'b0);
         chk1("b2b_mem_req", mem_req, 1'b0);
      end

      // Line change
      go();
      addr = 32'h0000_2000;
      exp_q.push_back(64'h2222_0000_0000_0000);
      smp();
      chk1("line_change_stall", stall_req, 1'b1);
      do_fill(32'h0000_2000, 64'h2222_0000_0000_0000, 0, -1);
      smp();
      chk1("line2_hit_stall", stall_req, 1'b0);

      // Old line gone; inval on beat 2 forces a second refill of the same line
      go();
      addr = 32'h0000_1008;
      exp_q.push_back(64'h4444_0000_0000_0001);
      smp();
      chk1("old_line_miss", stall_req, 1'b1);
      do_fill(32'h0000_1000, 64'h3333_0000_0000_0000, 1, 2);
      smp();
      chk1("drop_refetch_stall", stall_req, 1'b1);
      chk1("drop_refetch_mem_req", mem_req, 1'b0);
      do_fill(32'h0000_1000, 64'h4444_0000_0000_0000, 0, -1);
      smp();
      chk1("refetch_hit_stall", stall_req, 1'b0);

      // Reset during FILL after beat 1, then stray beats
      go();
      addr = 32'h0000_3000;
      smp();
      chk1("t5_miss_stall", stall_req, 1'b1);
      go();
      mem_ready = 1'b1;
      smp();
      chk1("t5_mem_req", mem_req, 1'b1);
      go();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555_0000_0000_0000;
      smp();
      go();
      mem_rdata = 64'h5555_0000_0000_0001;
      smp();
      go();
      mem_rvalid = 1'b0; rst = 1'b1; en = 1'b0;
      smp();
      go();
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0000;
      smp();
      chk1("post_rst_mem_req", mem_req, 1'b0);
      chk1("post_rst_stall", stall_req, 1'b0);
      chk64("post_rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      go();
      mem_rdata = 64'hDEAD_BEEF_0000_0001;
      smp();
      chk1("stray_mem_req", mem_req, 1'b0);
      go();
      mem_rvalid = 1'b0; en = 1'b1; addr = 32'h0000_3008;
      exp_q.push_back(64'h6666_0000_0000_0001);
      smp();
      chk1("post_rst_miss", stall_req, 1'b1);
      do_fill(32'h0000_3000, 64'h6666_0000_0000_0000, 0, -1);
      smp();
      chk1("post_rst_hit_stall", stall_req, 1'b0);

      // inval together with a request on a valid line
      go();
      addr = 32'h0000_3010; inval = 1'b1;
      exp_q.push_back(64'h7777_0000_0000_0002);
      smp();
      chk1("inval_en_stall", stall_req, 1'b1);
      chk1("inval_en_mem_req", mem_req, 1'b0);
      do_fill(32'h0000_3000, 64'h7777_0000_0000_0000, 0, -1);
      smp();
      chk1("inval_en_hit_stall", stall_req, 1'b0);

      go();
      en = 1'b0;
      smp();
      go();
      smp();
      chk64("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
